usrt_tx: RTL and testbench



---
 rtl/usrt_tx_if.sv | 12 +
 rtl/usrt_tx.sv | 109 ++++++++++
 tb/tb_usrt_tx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usrt_tx_if.sv
// Byte handshake between the bus side and the USRT transmit engine.
// Signal names are taken from the engine's point of view.
interface usrt_tx_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_Tx_Valid;
   logic [DATA_BITS-1:0] i_Tx_Data;
   logic                 o_Tx_Ready;

   modport master (output i_Tx_Valid, output i_Tx_Data, input o_Tx_Ready);
   modport slave  (input i_Tx_Valid, input i_Tx_Data, output o_Tx_Ready);
endinterface

// File: rtl/usrt_tx.sv
// USRT transmit engine: start, LSB-first data, optional parity and stop bits on
// o_Txd, with a self-generated bit clock o_Sclk (falling edge launches each bit).
module usrt_tx #(
   parameter int DATA_BITS = 8,
   parameter int DIV_WIDTH = 9
) (
   input  logic        i_Pclk,
   input  logic        i_Reset_n,
   input  logic [7:0]  i_Config,
   usrt_tx_if.slave    tx_bus,
   output logic        o_Tx_Busy,
   output logic        o_Txd,
   output logic        o_Sclk,
   output logic        o_Done
);

   localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               r_State;
   state_t               w_Next;
   logic [DIV_WIDTH-1:0] r_Cnt;
   logic [DIV_WIDTH-1:0] w_N;
   logic [DIV_WIDTH-1:0] w_Half;
   logic [BCW-1:0]       r_BitCnt;
   logic [DATA_BITS-1:0] r_Shift;
   logic [2:0]           r_Sel;
   logic                 r_ParEn;
   logic                 r_ParBit;
   logic                 w_Accept;
   logic                 w_BitEnd;
   logic                 w_unused_cfg;

   // Bit timing comes from the setting snapshot taken at acceptance.
   assign w_N          = DIV_WIDTH'(2) << r_Sel;
   assign w_Half       = w_N >> 1;
   assign w_BitEnd     = (r_Cnt == (w_N - DIV_WIDTH'(1)));
   assign w_Accept     = tx_bus.i_Tx_Valid && (r_State == IDLE);
   assign w_unused_cfg = ^i_Config[7:5];

   always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_State <= IDLE;
      end else begin
         r_State <= w_Next;
      end
   end

   always_comb begin
      w_Next = r_State;
      case (r_State)
         IDLE:    if (w_Accept) w_Next = START;
         START:   if (w_BitEnd) w_Next = DATA;
         DATA: begin
            if (w_BitEnd && (r_BitCnt == LAST_BIT)) begin
               w_Next = r_ParEn ? PARITY : STOP;
            end
         end
         PARITY:  if (w_BitEnd) w_Next = STOP;
         STOP:    if (w_BitEnd) w_Next = IDLE;
         default: w_Next = IDLE;
      endcase
   end

   always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_Cnt    <= '0;
         r_BitCnt <= '0;
         r_Shift  <= '0;
         r_Sel    <= '0;
         r_ParEn  <= 1'b0;
         r_ParBit <= 1'b0;
      end else if (r_State == IDLE) begin
         r_Cnt    <= '0;
         r_BitCnt <= '0;
         if (w_Accept) begin
            r_Shift  <= tx_bus.i_Tx_Data;
            r_Sel    <= i_Config[2:0];
            // Mode 11 is treated as no parity; odd mode inverts the data XOR.
            r_ParEn  <= i_Config[4] ^ i_Config[3];
            r_ParBit <= (^tx_bus.i_Tx_Data) ^ i_Config[4];
         end
      end else begin
         r_Cnt <= w_BitEnd ? '0 : (r_Cnt + DIV_WIDTH'(1));
         if ((r_State == DATA) && w_BitEnd) begin
            r_Shift  <= r_Shift >> 1;
            r_BitCnt <= (r_BitCnt == LAST_BIT) ? '0 : (r_BitCnt + BCW'(1));
         end
      end
   end

   always_comb begin
      o_Txd = 1'b1;
      case (r_State)
         START:   o_Txd = 1'b0;
         DATA:    o_Txd = r_Shift[0];
         PARITY:  o_Txd = r_ParBit;
         default: o_Txd = 1'b1;
      endcase
   end

   assign o_Sclk            = (r_State == IDLE) ? 1'b1 : (r_Cnt >= w_Half);
   assign o_Done            = (r_State == STOP) && w_BitEnd;
   assign o_Tx_Busy         = (r_State != IDLE);
   assign tx_bus.o_Tx_Ready = (r_State == IDLE);

endmodule

// File: tb/tb_usrt_tx.sv
// Scoreboard bench for usrt_tx: directed frames are queued with hand-written bit
// sequences and a negedge monitor checks every cycle of each frame it observes.
module tb_usrt_tx;

   localparam int DATA_BITS = 8;
   localparam int DIV_WIDTH = 9;

   logic       clk = 1'b0;
   logic       rstN;
   logic [7:0] cfg;
   logic       busy;
   logic       txd;
   logic       sclk;
   logic       done;

   usrt_tx_if #(.DATA_BITS(DATA_BITS)) txBus ();

   usrt_tx #(.DATA_BITS(DATA_BITS), .DIV_WIDTH(DIV_WIDTH)) dut (
      .i_Pclk    (clk),
      .i_Reset_n (rstN),
      .i_Config  (cfg),
      .tx_bus    (txBus),
      .o_Tx_Busy (busy),
      .o_Txd     (txd),
      .o_Sclk    (sclk),
      .o_Done    (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          n;
      int          gap;
      bit          abort;
   } expFrame_t;

   expFrame_t sbQ[$];
   int checks       = 0;
   int errors       = 0;
   int framesIssued = 0;
   int framesSeen   = 0;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor state: one frame is tracked from busy rising to busy falling.
   bit        inFrame = 1'b0;
   expFrame_t cur;
   int        idx, txdBad, sclkBad, doneBad, doneCnt, sclkRises, bitIdx, cPos;
   int        gapCnt = 1000;
   logic      prevSclk;

   always @(negedge clk) begin
      if (busy === 1'b1) begin
         if (!inFrame) begin
            inFrame   = 1'b1;
            framesSeen++;
            idx       = 0;
            txdBad    = 0;
            sclkBad   = 0;
            doneBad   = 0;
            doneCnt   = 0;
            sclkRises = 0;
            prevSclk  = 1'b1;
            if (sbQ.size() == 0) begin
               checkOutput("unexpected frame", 1, 0);
               cur.bits  = '0;
               cur.nbits = 1;
               cur.n     = 2;
               cur.gap   = -1;
               cur.abort = 1'b0;
            end else begin
               cur = sbQ.pop_front();
               if (cur.gap >= 0) checkOutput("inter-frame gap", gapCnt, cur.gap);
            end
         end
         bitIdx = idx / cur.n;
         cPos   = idx % cur.n;
         if (bitIdx >= cur.nbits) txdBad++;
         else if (txd !== cur.bits[bitIdx]) txdBad++;
         if (sclk !== (cPos >= cur.n / 2)) sclkBad++;
         if ((sclk === 1'b1) && (prevSclk === 1'b0)) sclkRises++;
         prevSclk = sclk;
         if (done === 1'b1) doneCnt++;
         if (done !== (idx == cur.nbits * cur.n - 1)) doneBad++;
         idx++;
      end else begin
         if (inFrame) begin
            if (cur.abort) begin
               checkOutput("abort seen under reset", int'(rstN === 1'b0), 1);
               checkOutput("abort done count", doneCnt, 0);
               checkOutput("abort txd prefix", txdBad, 0);
               checkOutput("abort sclk prefix", sclkBad, 0);
            end else begin
               checkOutput("frame length", idx, cur.nbits * cur.n);
               checkOutput("txd bit errors", txdBad, 0);
               checkOutput("sclk pattern errors", sclkBad, 0);
               checkOutput("done position errors", doneBad, 0);
               checkOutput("done count", doneCnt, 1);
               checkOutput("sclk rising edges", sclkRises, cur.nbits);
            end
            inFrame = 1'b0;
            gapCnt  = 1;
         end else begin
            gapCnt++;
         end
      end
   end

   // Queues the expected frame, then offers the byte until it is accepted.
   task automatic applyStimulus(input logic [7:0] cfgVal, input logic [7:0] data,
                                input string bits, input int n, input int gap,
                                input bit abort, input bit keepValid);
      expFrame_t e;
      bit        got;
      e.bits = '0;
      for (int i = 0; i < bits.len(); i++) e.bits[i] = (bits[i] == "1");
      e.nbits = bits.len();
      e.n     = n;
      e.gap   = gap;
      e.abort = abort;
      sbQ.push_back(e);
      framesIssued++;
      @(negedge clk);
      cfg               = cfgVal;
      txBus.i_Tx_Data   = data;
      txBus.i_Tx_Valid  = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         if (txBus.o_Tx_Ready === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         checkOutput("handshake timeout", 0, 1);
         txBus.i_Tx_Valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         if (!keepValid) txBus.i_Tx_Valid = 1'b0;
      end
   endtask

   task automatic waitIdle();
      bit idle;
      idle = 1'b0;
      for (int t = 0; t < 5000; t++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            idle = 1'b1;
            break;
         end
      end
      if (!idle) checkOutput("idle timeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstN             = 1'b0;
      cfg              = 8'h00;
      txBus.i_Tx_Valid = 1'b0;
      txBus.i_Tx_Data  = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset txd", int'(txd), 1);
      checkOutput("reset sclk", int'(sclk), 1);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset ready", int'(txBus.o_Tx_Ready), 1);
      checkOutput("reset done", int'(done), 0);
      rstN = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] basic frames and parity modes");
      applyStimulus(8'h00, 8'hA5, "0101001011", 2, -1, 1'b0, 1'b0);
      waitIdle();
      applyStimulus(8'h08, 8'h07, "01110000011", 2, -1, 1'b0, 1'b0);
      waitIdle();
      applyStimulus(8'h10, 8'h07, "01110000001", 2, -1, 1'b0, 1'b0);
      waitIdle();
      applyStimulus(8'h18, 8'h07, "0111000001", 2, -1, 1'b0, 1'b0);
      waitIdle();
      applyStimulus(8'h12, 8'h00, "00000000011", 8, -1, 1'b0, 1'b0);
      waitIdle();

      $display("[TB] cfg change and valid pulse while busy");
      applyStimulus(8'h00, 8'h3C, "0001111001", 2, -1, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      cfg = 8'h07;
      repeat (2) @(negedge clk);
      txBus.i_Tx_Data  = 8'hFF;
      txBus.i_Tx_Valid = 1'b1;
      @(negedge clk);
      txBus.i_Tx_Valid = 1'b0;
      waitIdle();
      repeat (30) @(negedge clk);
      checkOutput("no stray frame", framesSeen, framesIssued);
      checkOutput("idle after ignored byte", int'(busy), 0);

      $display("[TB] back-to-back frames");
      applyStimulus(8'h00, 8'h55, "0101010101", 2, -1, 1'b0, 1'b1);
      applyStimulus(8'h00, 8'hAA, "0010101011", 2, 1, 1'b0, 1'b0);
      waitIdle();

      $display("[TB] reset during data bit 3");
      applyStimulus(8'h00, 8'h5A, "0010110101", 2, -1, 1'b1, 1'b0);
      repeat (8) @(posedge clk);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("async reset txd", int'(txd), 1);
      checkOutput("async reset sclk", int'(sclk), 1);
      checkOutput("async reset busy", int'(busy), 0);
      checkOutput("async reset done", int'(done), 0);
      checkOutput("async reset ready", int'(txBus.o_Tx_Ready), 1);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus(8'h00, 8'h81, "0100000011", 2, -1, 1'b0, 1'b0);
      waitIdle();

      checkOutput("scoreboard drained", sbQ.size(), 0);
      checkOutput("frames observed", framesSeen, framesIssued);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
